// File: rtl/ltc_frame_encoder_if.sv
// Control/status bundle between the pin wrapper and the LTC frame encoder.
interface ltc_frame_encoder_if;
  logic        run;
  logic        tc_load;
  logic [31:0] tc_in;
  logic [31:0] ub_in;
  logic        ltc_out;
  logic        frame_start;
  logic [31:0] tc_out;
  logic        busy;
  logic        load_err;

  // Wrapper side: drives controls, observes the encoder.
  modport master (
    output run, tc_load, tc_in, ub_in,
    input  ltc_out, frame_start, tc_out, busy, load_err
  );

  // Encoder side.
  modport slave (
    input  run, tc_load, tc_in, ub_in,
    output ltc_out, frame_start, tc_out, busy, load_err
  );
endinterface

// File: rtl/ltc_frame_encoder.sv
// SMPTE 12M linear timecode generator: BCD timecode counter, 80-bit frame builder and
// biphase-mark line driver timed by an exact fractional half-bit accumulator.
module ltc_frame_encoder #(
  parameter int unsigned CLK_HZ = 10_000_000,
  parameter int unsigned FPS    = 25
) (
  input logic                clk,
  input logic                rst,
  ltc_frame_encoder_if.slave bus
);

  localparam int unsigned Inc      = 160 * FPS;
  localparam logic [7:0]  FfMax    = 8'((((FPS - 1) / 10) * 16) + ((FPS - 1) % 10));
  // Sync word with bit 64 (first transmitted) in the LSB.
  localparam logic [15:0] SyncWord = 16'hBFFC;
  localparam logic [6:0]  LastBit  = 7'd79;

  if (!(FPS == 24 || FPS == 25 || FPS == 30)) begin : g_bad_fps
    $error("ltc_frame_encoder: FPS must be 24, 25 or 30");
  end
  if (CLK_HZ < 2 * FPS * 160) begin : g_bad_clk
    $error("ltc_frame_encoder: CLK_HZ too low for the half-bit rate");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Advance one BCD field, wrapping to zero once it reaches vmax.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] vmax);
    logic [7:0] r;
    if (v == vmax) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Timecode one frame later; carries are decided on the original field values.
  function automatic logic [31:0] tc_next(input logic [31:0] tc);
    logic [7:0] hh, mm, ss, ff;
    {hh, mm, ss, ff} = tc;
    if (ff == FfMax) begin
      if (ss == 8'h59) begin
        if (mm == 8'h59) begin
          hh = bcd_step(hh, 8'h23);
        end
        mm = bcd_step(mm, 8'h59);
      end
      ss = bcd_step(ss, 8'h59);
    end
    ff = bcd_step(ff, FfMax);
    return {hh, mm, ss, ff};
  endfunction

  // Range check for a timecode presented on tc_in.
  function automatic logic load_ok(input logic [31:0] tc);
    logic       ok;
    logic [7:0] ff_bin;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (tc[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    ff_bin = (8'(tc[7:4]) * 8'd10) + 8'(tc[3:0]);
    if (ff_bin >= 8'(FPS)) ok = 1'b0;
    if (tc[15:12] > 4'd5) ok = 1'b0;
    if (tc[23:20] > 4'd5) ok = 1'b0;
    if ((tc[31:28] > 4'd2) || ((tc[31:28] == 4'd2) && (tc[27:24] > 4'd3))) ok = 1'b0;
    return ok;
  endfunction

  // Assemble the 80 frame bits, bit 0 first on the line.
  function automatic logic [79:0] build_frame(input logic [31:0] tc, input logic [31:0] ub);
    logic [79:0] f;
    f        = '0;
    f[3:0]   = tc[3:0];
    f[7:4]   = ub[3:0];
    f[9:8]   = tc[5:4];
    f[15:12] = ub[7:4];
    f[19:16] = tc[11:8];
    f[23:20] = ub[11:8];
    f[26:24] = tc[14:12];
    f[31:28] = ub[15:12];
    f[35:32] = tc[19:16];
    f[39:36] = ub[19:16];
    f[42:40] = tc[22:20];
    f[47:44] = ub[23:20];
    f[51:48] = tc[27:24];
    f[55:52] = ub[27:24];
    f[57:56] = tc[29:28];
    f[63:60] = ub[31:28];
    f[79:64] = SyncWord;
    // Even popcount keeps every frame starting on a rising edge.
    if (FPS == 25) begin
      f[59] = ^f;
    end else begin
      f[27] = ^f;
    end
    return f;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d, acc_sum;
  logic        half_q, half_d;
  logic [6:0]  bit_q, bit_d;
  logic [79:0] frame_q, frame_d;
  logic        ltc_q, ltc_d;
  logic        fs_q, fs_d;
  logic        err_q, err_d;
  logic [31:0] tc_out_q, tc_out_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] frame_tc;
  logic        half_tick;
  logic        start;

  assign acc_sum   = acc_q + 32'(Inc);
  assign half_tick = (state_q == StRun) && (acc_sum >= 32'(CLK_HZ));
  assign frame_tc  = pend_valid_q ? pend_q : cnt_q;

  // Next-state: half-bit sequencing, frame starts and load handling.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    half_d       = half_q;
    bit_d        = bit_q;
    frame_d      = frame_q;
    ltc_d        = ltc_q;
    fs_d         = 1'b0;
    err_d        = 1'b0;
    tc_out_d     = tc_out_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    start        = 1'b0;

    unique case (state_q)
      StIdle: begin
        acc_d = '0;
        if (bus.run) start = 1'b1;
      end
      StRun: begin
        acc_d = half_tick ? (acc_sum - 32'(CLK_HZ)) : acc_sum;
        if (half_tick) begin
          if (!half_q) begin
            half_d = 1'b1;
            if (frame_q[0]) ltc_d = ~ltc_q;
          end else if (bit_q != LastBit) begin
            half_d  = 1'b0;
            bit_d   = bit_q + 7'd1;
            frame_d = frame_q >> 1;
            ltc_d   = ~ltc_q;
          end else if (bus.run) begin
            start = 1'b1;
          end else begin
            state_d = StIdle;
            acc_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d      = StRun;
      half_d       = 1'b0;
      bit_d        = '0;
      frame_d      = build_frame(frame_tc, bus.ub_in);
      ltc_d        = ~ltc_q;
      fs_d         = 1'b1;
      tc_out_d     = frame_tc;
      cnt_d        = tc_next(frame_tc);
      pend_valid_d = 1'b0;
    end

    // A load accepted this cycle outranks the pending-clear of a frame start.
    if (bus.tc_load) begin
      if (load_ok(bus.tc_in)) begin
        pend_d       = bus.tc_in;
        pend_valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      half_q       <= 1'b0;
      bit_q        <= '0;
      frame_q      <= '0;
      ltc_q        <= 1'b0;
      fs_q         <= 1'b0;
      err_q        <= 1'b0;
      tc_out_q     <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      half_q       <= half_d;
      bit_q        <= bit_d;
      frame_q      <= frame_d;
      ltc_q        <= ltc_d;
      fs_q         <= fs_d;
      err_q        <= err_d;
      tc_out_q     <= tc_out_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign bus.ltc_out     = ltc_q;
  assign bus.frame_start = fs_q;
  assign bus.tc_out      = tc_out_q;
  assign bus.busy        = (state_q == StRun);
  assign bus.load_err    = err_q;

endmodule
